// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader for a combinational 3x3 matrix multiplier.
// Collects 18 bytes (A then B, row-major) and holds them until the consumer acks.
module matrix_operand_loader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clr,
    input  logic              mat_ack,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] a3,
    output logic [DATA_W-1:0] a4,
    output logic [DATA_W-1:0] a5,
    output logic [DATA_W-1:0] a6,
    output logic [DATA_W-1:0] a7,
    output logic [DATA_W-1:0] a8,
    output logic [DATA_W-1:0] a9,
    output logic [DATA_W-1:0] b1,
    output logic [DATA_W-1:0] b2,
    output logic [DATA_W-1:0] b3,
    output logic [DATA_W-1:0] b4,
    output logic [DATA_W-1:0] b5,
    output logic [DATA_W-1:0] b6,
    output logic [DATA_W-1:0] b7,
    output logic [DATA_W-1:0] b8,
    output logic [DATA_W-1:0] b9,
    output logic              mat_valid,
    output logic [4:0]        load_cnt
);

    localparam int          N_ELEM   = 18;
    localparam logic [4:0]  LAST_IDX = 5'd17;

    typedef enum logic {
        LOAD,
        HOLD
    } state_t;

    state_t            state_reg, state_next;
    logic [4:0]        cnt_reg, cnt_next;
    logic              accept;
    logic [DATA_W-1:0] elem_reg [N_ELEM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD;
            cnt_reg   <= 5'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // clr takes priority over both accept and ack, in either state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        in_ready   = 1'b0;
        mat_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            LOAD: begin
                in_ready = 1'b1;
                if (clr) begin
                    cnt_next = 5'd0;
                end else if (in_valid) begin
                    accept   = 1'b1;
                    cnt_next = cnt_reg + 5'd1;
                    if (cnt_reg == LAST_IDX) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                mat_valid = 1'b1;
                if (clr || mat_ack) begin
                    state_next = LOAD;
                    cnt_next   = 5'd0;
                end
            end
            default: begin
                state_next = LOAD;
                cnt_next   = 5'd0;
            end
        endcase
    end

    // Element k is written directly at the edge that accepts it; no staging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ELEM; i++) begin
                elem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (accept && (cnt_reg == 5'(i))) begin
                    elem_reg[i] <= in_data;
                end
            end
        end
    end

    assign load_cnt = cnt_reg;

    assign a1 = elem_reg[0];
    assign a2 = elem_reg[1];
    assign a3 = elem_reg[2];
    assign a4 = elem_reg[3];
    assign a5 = elem_reg[4];
    assign a6 = elem_reg[5];
    assign a7 = elem_reg[6];
    assign a8 = elem_reg[7];
    assign a9 = elem_reg[8];
    assign b1 = elem_reg[9];
    assign b2 = elem_reg[10];
    assign b3 = elem_reg[11];
    assign b4 = elem_reg[12];
    assign b5 = elem_reg[13];
    assign b6 = elem_reg[14];
    assign b7 = elem_reg[15];
    assign b8 = elem_reg[16];
    assign b9 = elem_reg[17];

endmodule
